counter_sync_down_nbits: RTL and testbench
==========================================

Name: counter_sync_down_nbits

Overview:
- Synchronous, loadable, parameterised down counter with terminal-count pulse. It is the decrementing, fully synchronous counterpart of the team's ripple up-counters.
- Used as a countdown timer or delay generator: a controller loads a value, the block counts to zero on enabled cycles, then signals completion.
- All state changes on the rising edge of clk; no ripple clocking.

Parameters:
- WIDTH, 4, counter and load-value width in bits (min 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_ah_in  input  1  synchronous reset, active-high.
- load_in  input  1  load request; captures load_value_in this edge.
- load_value_in  input  WIDTH  start value for the countdown.
- enable_in  input  1  count enable; one decrement per enabled edge while running.
- count_out  output  WIDTH  current count, registered.
- zero_out  output  1  high when count_out == 0.
- tc_pulse_out  output  1  one-cycle pulse in the cycle count_out first becomes 0 by decrement.
- busy_out  output  1  high while in RUN.

Behaviour:
- Interface (already decided): one clock, clk. Reset reset_ah_in is synchronous and active-high.
- Reset (sampled on clk edge, overrides all inputs):
  - count_out=0, state=IDLE, tc_pulse_out=0, busy_out=0, zero_out=1.
  - Stored reload value=0.
- States:
  - IDLE: count held; enable_in ignored. There is no wrap from 0 to 2^WIDTH-1.
  - RUN: decrement on each edge with enable_in=1; hold when enable_in=0.
- Load (priority over enable and over terminal-count detection):
  - On an edge with load_in=1, in either state: count_out<=load_value_in and stored reload value<=load_value_in.
  - If load_value_in != 0, state<=RUN. If load_value_in == 0, state<=IDLE and no tc pulse.
  - Latency: count_out shows the loaded value in the cycle after the load edge.
- Terminal count: in RUN with enable_in=1 and count_out==1, count_out<=0, tc_pulse_out<=1 for exactly one cycle, and state<=IDLE (base build).
- tc_pulse_out is registered and deasserts on the following edge unconditionally.
- Load on the same edge as 1->0: the load wins, count takes load_value_in, and no tc pulse is generated.
- A count value of 0 while in RUN is unreachable in the base build.
- Reset mid-RUN: behaves as power-on reset; any pending tc pulse is cleared.
- Arithmetic: unsigned, modulo 2^WIDTH. A maximum load of 2^WIDTH-1 takes 2^WIDTH-1 enabled edges to reach 0.
- busy_out = (state==RUN). zero_out is decoded combinationally from the count register.

Optional Feature:
- Macro: COUNTER_AUTO_RELOAD_EN
- Defined:
  - On 1->0 the state stays RUN (tc pulse as in the base build).
  - On the next enabled edge with count_out==0 in RUN, count_out<=stored reload value.
  - Period is N+1 enabled cycles for reload value N. Sequence for N=3: 3,2,1,0,3,2,1,0,…
  - Only load of 0 or reset returns the block to IDLE.
- Undefined: base behaviour; the counter stops at 0 in IDLE.

Decomposition:
- Shared package counter_pkg holds:
  - state typedef (IDLE, RUN) as a 1-bit enum;
  - localparam default width 4.
- No sub-module. The next-state logic, count register and tc register are small enough for a single module.

Test Plan:
- Reset: assert reset_ah_in 2 cycles with load_in=1, load_value_in=9 -> count_out=0, zero_out=1, busy_out=0, tc_pulse_out=0. Load is ignored.
- Basic countdown: load 3, enable_in held 1 -> count_out 3,2,1,0 on consecutive cycles; tc_pulse_out=1 only in the cycle count=0; busy_out falls with it. Further enables keep count at 0, with no wrap to 15.
- Enable gaps: load 5, toggle enable_in 1,0,1,0… -> count decrements only on enabled edges; 10 cycles to reach 0; exactly one tc pulse.
- Load priority: while counting, at count_out==1 assert load_in with value 7 on the edge that would reach 0 -> count_out=7, no tc pulse, busy_out stays 1. Load 0 -> count 0, IDLE, no tc pulse.
- Reset mid-run: load 15, run 4 cycles (count 11), assert reset_ah_in -> next cycle count_out=0, IDLE, tc_pulse_out=0. With COUNTER_AUTO_RELOAD_EN, the counter does not resume after reset.
- With COUNTER_AUTO_RELOAD_EN: load 2, enable held -> 2,1,0,2,1,0,2…; tc pulse every 3 cycles; busy_out constant 1. Load 0 -> stops in IDLE.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the synchronous down counter family.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_sync_down_nbits.sv
// Synchronous loadable down counter with registered terminal-count pulse.
// Define COUNTER_AUTO_RELOAD_EN to make the counter reload its stored value after reaching zero.
module counter_sync_down_nbits
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    input  logic             enable_in,
    output logic [WIDTH-1:0] count_out,
    output logic             zero_out,
    output logic             tc_pulse_out,
    output logic             busy_out
);

    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_value;
    logic             tc_pulse;

    always_ff @(posedge clk) begin
        if (reset_ah_in) begin
            state        <= IDLE;
            count        <= '0;
            reload_value <= '0;
            tc_pulse     <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            if (load_in) begin
                // Load outranks the 1->0 step, so a load on that edge suppresses the pulse.
                count        <= load_value_in;
                reload_value <= load_value_in;
                state        <= (load_value_in != '0) ? RUN : IDLE;
            end else if (state == RUN && enable_in) begin
                if (count == COUNT_ONE) begin
                    count    <= '0;
                    tc_pulse <= 1'b1;
`ifdef COUNTER_AUTO_RELOAD_EN
                    state    <= RUN;
`else
                    state    <= IDLE;
`endif
`ifdef COUNTER_AUTO_RELOAD_EN
                end else if (count == '0) begin
                    count <= reload_value;
`endif
                end else begin
                    count <= count - COUNT_ONE;
                end
            end
        end
    end

    assign count_out    = count;
    assign zero_out     = (count == '0);
    assign tc_pulse_out = tc_pulse;
    assign busy_out     = (state == RUN);

endmodule

// File: tb/tb_counter_sync_down_nbits.sv
// Scoreboard bench for counter_sync_down_nbits against a behavioural countdown model.
module tb_counter_sync_down_nbits;

    localparam int unsigned W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset_ah_in = 1'b0;
    logic         load_in = 1'b0;
    logic [W-1:0] load_value_in = '0;
    logic         enable_in = 1'b0;
    logic [W-1:0] count_out;
    logic         zero_out;
    logic         tc_pulse_out;
    logic         busy_out;

    counter_sync_down_nbits #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_ah_in   (reset_ah_in),
        .load_in       (load_in),
        .load_value_in (load_value_in),
        .enable_in     (enable_in),
        .count_out     (count_out),
        .zero_out      (zero_out),
        .tc_pulse_out  (tc_pulse_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   count;
        logic zero;
        logic tc;
        logic busy;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

`ifdef COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Reference model: remaining count, whether a countdown is active, and the last loaded value.
    int m_cnt = 0;
    bit m_run = 1'b0;
    int m_rel = 0;

    task automatic drive(input bit r, input bit l, input int v, input bit e);
        exp_t x;
        bit   tc;
        @(negedge clk);
        reset_ah_in   = r;
        load_in       = l;
        load_value_in = W'(v);
        enable_in     = e;
        tc = 1'b0;
        if (r) begin
            m_cnt = 0; m_run = 1'b0; m_rel = 0;
        end else if (l) begin
            m_cnt = v; m_rel = v; m_run = (v != 0);
        end else if (m_run && e) begin
            if (m_cnt == 0) begin
                m_cnt = m_rel;
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    tc    = 1'b1;
                    m_run = AUTO;
                end
            end
        end
        x.count = m_cnt;
        x.zero  = (m_cnt == 0);
        x.tc    = tc;
        x.busy  = m_run;
        q.push_back(x);
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    // Monitor: the DUT presents a new output set after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("count_out", (^count_out === 1'bx) ? -1 : int'(count_out), x.count);
                check("zero_out", (zero_out === 1'bx) ? -1 : int'(zero_out), int'(x.zero));
                check("tc_pulse_out", (tc_pulse_out === 1'bx) ? -1 : int'(tc_pulse_out), int'(x.tc));
                check("busy_out", (busy_out === 1'bx) ? -1 : int'(busy_out), int'(x.busy));
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $fatal(1);
    end

    initial begin
        // Reset with a load request present: the load must be ignored.
        drive(1, 1, 9, 1);
        drive(1, 1, 9, 1);
        drive(0, 0, 0, 0);

        // Basic countdown, then extra enables at zero must not wrap.
        drive(0, 1, 3, 1);
        repeat (7) drive(0, 0, 0, 1);

        // Enable gaps.
        drive(0, 1, 5, 0);
        for (int i = 0; i < 14; i++) drive(0, 0, 0, (i % 2) == 0);

        // Load colliding with the 1->0 step, then load of zero.
        drive(0, 1, 3, 1);
        for (int i = 0; i < 10 && m_cnt != 1; i++) drive(0, 0, 0, 1);
        drive(0, 1, 7, 1);
        drive(0, 0, 0, 1);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);

        // Reset in the middle of a maximum-length run.
        drive(0, 1, MAXV, 1);
        repeat (4) drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 1);

        // Full maximum countdown.
        drive(0, 1, MAXV, 1);
        repeat (MAXV + 2) drive(0, 0, 0, 1);

        // Auto-reload period check (base build simply stops at zero).
        drive(0, 1, 2, 1);
        repeat (9) drive(0, 0, 0, 1);
        drive(0, 1, 0, 1);
        repeat (3) drive(0, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, l, e;
            int v;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 8);
            e = ($urandom_range(0, 99) < 75);
            case ($urandom_range(0, 5))
                0:       v = 0;
                1:       v = 1;
                2:       v = MAXV;
                default: v = $urandom_range(0, MAXV);
            endcase
            drive(r, l, v, e);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        stim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
